kernel_window_gen: RTL and testbench

Streaming window generator that turns a raster pixel stream into the KERNEL_SIZE×KERNEL_SIZE neighbourhood consumed by `processing_Gx_Gy`. It stores the previous KERNEL_SIZE-1 image lines and shifts a register window one column per accepted pixel. For every pixel whose full window lies inside the frame, it presents the window together with valid and start-of-frame flags. It sits between the pixel source and the gradient stage, and drives that stage's kernel buffer, valid and start-of-frame inputs directly.

---
 rtl/kernel_window_gen.sv | 147 ++++++++++++++
 tb/tb_kernel_window_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_window_gen.sv
// rtl/kernel_window_gen.sv - raster stream to KERNEL_SIZE x KERNEL_SIZE window generator
// Optional end-of-frame output enabled by defining KERNEL_WINDOW_GEN_EOF_EN.
module kernel_window_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_start_of_frame,
    output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic                  o_data_valid,
`ifdef KERNEL_WINDOW_GEN_EOF_EN
    output logic                  o_end_of_frame,
`endif
    output logic                  o_start_of_frame
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] FIRST_EMIT_COL = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] FIRST_EMIT_ROW = RW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   col, col_next, pix_col;
    logic [RW-1:0]   row, row_next, pix_row;
    logic            take, last_pix, emit, emit_sof, emit_eof;

    // Previous KERNEL_SIZE-1 lines; entry 0 holds the most recent line
    logic [DATA_WIDTH-1:0] line_buf [0:KERNEL_SIZE-2][0:IMAGE_WIDTH-1];

    // Accept decision, effective pixel position, next counters/state and emission flags
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        take       = 1'b0;
        pix_col    = col;
        pix_row    = row;
        last_pix   = 1'b0;
        emit       = 1'b0;
        emit_sof   = 1'b0;
        emit_eof   = 1'b0;
        if (i_data_valid) begin
            if (i_start_of_frame) begin
                // sof always restarts at (0,0), aborting any frame in progress
                take    = 1'b1;
                pix_col = '0;
                pix_row = '0;
            end else if (state == S_ACTIVE) begin
                take = 1'b1;
            end
        end
        last_pix = (pix_col == LAST_COL) && (pix_row == LAST_ROW);
        emit     = take && (pix_row >= FIRST_EMIT_ROW) && (pix_col >= FIRST_EMIT_COL);
        emit_sof = emit && (pix_row == FIRST_EMIT_ROW) && (pix_col == FIRST_EMIT_COL);
        emit_eof = emit && last_pix;
        if (take) begin
            if (last_pix) begin
                state_next = S_DONE;
                col_next   = '0;
                row_next   = '0;
            end else if (pix_col == LAST_COL) begin
                state_next = S_ACTIVE;
                col_next   = '0;
                row_next   = pix_row + 1'b1;
            end else begin
                state_next = S_ACTIVE;
                col_next   = pix_col + 1'b1;
                row_next   = pix_row;
            end
        end
    end

    // State and raster position registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    // Line buffers shift one line deeper at the current column; contents need no reset
    always_ff @(posedge clk) begin
        if (take) begin
            for (int k = KERNEL_SIZE - 2; k >= 1; k--) begin
                line_buf[k][pix_col] <= line_buf[k-1][pix_col];
            end
            line_buf[0][pix_col] <= i_data;
        end
    end

    // Window shifts left one column per accepted pixel; flags pulse for one cycle
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    o_image_kernel_buffer[r][c] <= '0;
                end
            end
            o_data_valid     <= 1'b0;
            o_start_of_frame <= 1'b0;
`ifdef KERNEL_WINDOW_GEN_EOF_EN
            o_end_of_frame   <= 1'b0;
`endif
        end else begin
            o_data_valid     <= emit;
            o_start_of_frame <= emit_sof;
`ifdef KERNEL_WINDOW_GEN_EOF_EN
            o_end_of_frame   <= emit_eof;
`endif
            if (take) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        o_image_kernel_buffer[r][c] <= o_image_kernel_buffer[r][c+1];
                    end
                end
                o_image_kernel_buffer[KERNEL_SIZE-1][KERNEL_SIZE-1] <= i_data;
                for (int k = 1; k < KERNEL_SIZE; k++) begin
                    o_image_kernel_buffer[KERNEL_SIZE-1-k][KERNEL_SIZE-1] <= line_buf[k-1][pix_col];
                end
            end
        end
    end

`ifndef KERNEL_WINDOW_GEN_EOF_EN
    logic unused_eof;
    assign unused_eof = emit_eof;
`endif

endmodule

// File: tb/tb_kernel_window_gen.sv
// tb/tb_kernel_window_gen.sv - scoreboard testbench for kernel_window_gen
module tb_kernel_window_gen;

    localparam int DW = 8;
    localparam int K  = 5;
    localparam int IW = 10;
    localparam int IH = 10;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_data_valid = 1'b0;
    logic          i_start_of_frame = 1'b0;
    logic [DW-1:0] win [0:K-1][0:K-1];
    logic          o_data_valid;
    logic          o_start_of_frame;
`ifdef KERNEL_WINDOW_GEN_EOF_EN
    logic          o_end_of_frame;
`endif

    kernel_window_gen #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .i_data(i_data),
        .i_data_valid(i_data_valid),
        .i_start_of_frame(i_start_of_frame),
        .o_image_kernel_buffer(win),
        .o_data_valid(o_data_valid),
`ifdef KERNEL_WINDOW_GEN_EOF_EN
        .o_end_of_frame(o_end_of_frame),
`endif
        .o_start_of_frame(o_start_of_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int row;
        int col;
        bit sof;
        bit eof;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   wins_seen = 0;
    int   stray_sof = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pix(input int mode, input int r, input int c);
        if (mode == 0) return (r * IW + c + 1) & 8'hff;
        return (200 - (r * IW + c)) & 8'hff;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare one expected window per output pulse
    always @(negedge clk) begin
        if (aresetn) begin
            if (o_start_of_frame && !o_data_valid) stray_sof++;
            if (o_data_valid) begin
                wins_seen++;
                if (q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    exp_t e;
                    int   bad_r, bad_c, got, want;
                    e = q.pop_front();
                    check("latency_cycle", cyc, e.due);
                    bad_r = -1; bad_c = -1; got = 0; want = 0;
                    for (int r = 0; r < K; r++) begin
                        for (int c = 0; c < K; c++) begin
                            if (bad_r < 0 && int'(win[r][c]) != pix(e.mode, e.row - (K-1) + r, e.col - (K-1) + c)) begin
                                bad_r = r; bad_c = c; got = int'(win[r][c]);
                                want = pix(e.mode, e.row - (K-1) + r, e.col - (K-1) + c);
                            end
                        end
                    end
                    if (bad_r >= 0)
                        $display("  window at pixel (%0d,%0d) differs at [%0d][%0d]", e.row, e.col, bad_r, bad_c);
                    check("window_contents", got, want);
                    check("window_sof", o_start_of_frame, e.sof);
`ifdef KERNEL_WINDOW_GEN_EOF_EN
                    check("window_eof", o_end_of_frame, e.eof);
`endif
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                check("missing_window", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input int mode, input int r, input int c, input bit sof, input bit live);
        i_data           = DW'(pix(mode, r, c));
        i_data_valid     = 1'b1;
        i_start_of_frame = sof;
        if (live && r >= K-1 && c >= K-1)
            q.push_back('{mode, r, c, (r == K-1 && c == K-1), (r == IH-1 && c == IW-1), cyc + 1});
        @(posedge clk);
        #1;
        i_data_valid     = 1'b0;
        i_start_of_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int mode, input int gap);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                send(mode, r, c, (r == 0 && c == 0), 1'b1);
                idle(gap);
            end
        end
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) send(0, 3, i, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        // Outputs during reset
        #23;
        check("reset_valid", o_data_valid, 0);
        check("reset_sof", o_start_of_frame, 0);
        check("reset_win00", win[0][0], 0);
        check("reset_win44", win[4][4], 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        idle(2);

        // Pixels before any sof are ignored
        send_junk(6);
        idle(3);
        check("idle_no_windows", wins_seen, 0);

        // Continuous frame
        start = wins_seen;
        send_frame(0, 0);
        idle(3);
        check("frame0_count", wins_seen - start, 36);
        check("frame0_last_win00", win[0][0], 56);
        check("frame0_last_win44", win[4][4], 100);

        // Extra pixels after the last pixel of the frame
        start = wins_seen;
        send_junk(7);
        idle(3);
        check("done_no_windows", wins_seen - start, 0);
        check("done_hold_win00", win[0][0], 56);

        // Same frame with 3 idle cycles after every pixel
        start = wins_seen;
        send_frame(0, 3);
        idle(3);
        check("gap_frame_count", wins_seen - start, 36);

        // Consecutive frame with different data
        start = wins_seen;
        send_frame(1, 0);
        idle(3);
        check("frame1_count", wins_seen - start, 36);
        check("frame1_last_win00", win[0][0], 145);
        check("frame1_last_win44", win[4][4], 101);

        // Frame A aborted by sof at (6,3), then full frame B
        start = wins_seen;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (r * IW + c < 6 * IW + 3) send(0, r, c, (r == 0 && c == 0), 1'b1);
            end
        end
        send_frame(1, 0);
        idle(3);
        check("abort_total_count", wins_seen - start, 12 + 36);

        // Reset pulsed at pixel (5,5), then a full frame
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (r * IW + c < 5 * IW + 5) send(0, r, c, (r == 0 && c == 0), 1'b1);
            end
        end
        @(negedge clk); #1;
        aresetn = 1'b0;
        #1;
        check("midreset_valid", o_data_valid, 0);
        check("midreset_win00", win[0][0], 0);
        check("midreset_win44", win[4][4], 0);
        idle(3);
        aresetn = 1'b1;
        idle(1);
        send_junk(4);
        idle(2);
        start = wins_seen;
        send_frame(0, 0);
        idle(3);
        check("post_reset_count", wins_seen - start, 36);

        check("queue_drained", q.size(), 0);
        check("stray_sof", stray_sof, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
